// File: rtl/irig_frame_decoder.sv
`default_nettype none
// ============================================================================
// irig_frame_decoder : IRIG-B deglitch, pulse classify, 100-pulse framing and
// AXI-Stream frame output. Optional macro IRIG_TS_COMP_EN.        Rev 1.0
// ============================================================================
module irig_frame_decoder #(
    parameter int COUNTER_W   = 64,
    parameter int FILTER_LEN  = 4,
    parameter int T0_CYC      = 175000,
    parameter int T1_CYC      = 325000,
    parameter int TPI_CYC     = 475000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                 clk_50MHz,
    input  logic                 resetn,
    input  logic [COUNTER_W-1:0] counter_in,
    input  logic                 irig_in,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 locked,
    output logic [15:0]          frame_err_cnt,
    output logic [15:0]          frame_drop_cnt
);

    localparam int             c_tmo_w     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [23:0]    c_width_max = 24'hFF_FFFF;
    localparam logic [23:0]    c_t0        = 24'(T0_CYC);
    localparam logic [23:0]    c_t1        = 24'(T1_CYC);
    localparam logic [23:0]    c_tpi       = 24'(TPI_CYC);
    localparam logic [3:0]     c_flt_last  = 4'(FILTER_LEN - 1);
    localparam logic [c_tmo_w-1:0] c_tmo   = c_tmo_w'(TIMEOUT_CYC);
    localparam logic [2:0]     c_ts_beats  = 3'(COUNTER_W / 32);
    localparam logic [2:0]     c_last_beat = c_ts_beats + 3'd3;
    localparam logic [1:0]     c_sym_zero  = 2'd0;
    localparam logic [1:0]     c_sym_one   = 2'd1;
    localparam logic [1:0]     c_sym_pi    = 2'd2;
    localparam logic [1:0]     c_sym_err   = 2'd3;

    typedef enum logic [1:0] {ST_HUNT, ST_SYNC1, ST_DECODE} frame_state_t;
    typedef enum logic       {OUT_IDLE, OUT_SEND}          out_state_t;

    logic                 r_sync1, r_sync2, r_filt, r_filt_d;
    logic [3:0]           r_flt_cnt;
    logic [23:0]          r_width;
    logic [c_tmo_w-1:0]   r_tmo;
    logic [COUNTER_W-1:0] r_rise_ts;
    logic                 r_evt;
    logic [1:0]           r_sym;
    frame_state_t         r_state;
    logic [6:0]           r_pos;
    logic [99:0]          r_bits;
    logic [COUNTER_W-1:0] r_sync_ts;
    out_state_t           r_out_state;
    logic [2:0]           r_beat;
    logic [63:0]          r_buf_ts;
    logic [99:0]          r_buf_bits;

    logic                 w_rise, w_fall, w_timeout, w_commit;
    logic                 w_expect_pi, w_sym_ok;
    logic [1:0]           w_sym;
    logic [COUNTER_W-1:0] w_edge_ts;
    logic [63:0]          w_ts64;

    assign w_rise    = r_filt & ~r_filt_d;
    assign w_fall    = ~r_filt & r_filt_d;
    assign w_timeout = (r_tmo == c_tmo);
    assign w_ts64    = 64'(r_sync_ts);

`ifdef IRIG_TS_COMP_EN
    localparam logic [COUNTER_W-1:0] c_latency = COUNTER_W'(FILTER_LEN + 2);
    assign w_edge_ts = counter_in - c_latency;
`else
    assign w_edge_ts = counter_in;
`endif

    always_comb begin
        w_sym = c_sym_err;
        if (r_width < c_t0)       w_sym = c_sym_zero;
        else if (r_width < c_t1)  w_sym = c_sym_one;
        else if (r_width < c_tpi) w_sym = c_sym_pi;
    end

    // Markers sit at 9,19,...,99; every other decoded position must be a data bit.
    always_comb begin
        w_expect_pi = (r_pos == 7'd99) || ((r_pos % 7'd10) == 7'd9);
        w_sym_ok    = w_expect_pi ? (r_sym == c_sym_pi)
                                  : ((r_sym == c_sym_zero) || (r_sym == c_sym_one));
        w_commit    = r_evt && !w_timeout && (r_state == ST_DECODE)
                      && (r_pos == 7'd99) && (r_sym == c_sym_pi);
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] beat_word(input logic [63:0] ts,
                                              input logic [99:0] b,
                                              input logic [2:0]  idx);
        logic [127:0] bb;
        logic [2:0]   k;
        bb = {28'd0, b};
        k  = idx - c_ts_beats;
        if (idx < c_ts_beats) begin
            beat_word = idx[0] ? ts[63:32] : ts[31:0];
        end else begin
            case (k)
                3'd0:    beat_word = bb[31:0];
                3'd1:    beat_word = bb[63:32];
                3'd2:    beat_word = bb[95:64];
                default: beat_word = bb[127:96];
            endcase
        end
    endfunction

    always_ff @(posedge clk_50MHz) begin
        if (!resetn) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_filt    <= 1'b0;
            r_filt_d  <= 1'b0;
            r_flt_cnt <= '0;
        end else begin
            r_sync1  <= irig_in;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            if (r_sync2 == r_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_flt_last) begin
                r_filt    <= r_sync2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 4'd1;
            end
        end
    end

    // The rise cycle is itself the first high cycle, so r_width equals the
    // filtered high time when the falling edge is seen.
    always_ff @(posedge clk_50MHz) begin
        if (!resetn) begin
            r_width   <= '0;
            r_tmo     <= '0;
            r_rise_ts <= '0;
            r_evt     <= 1'b0;
            r_sym     <= c_sym_zero;
        end else begin
            if (w_rise) begin
                r_rise_ts <= w_edge_ts;
                r_width   <= 24'd1;
            end else if (r_filt && (r_width != c_width_max)) begin
                r_width   <= r_width + 24'd1;
            end
            if (w_rise)              r_tmo <= '0;
            else if (r_tmo != c_tmo) r_tmo <= r_tmo + c_tmo_w'(1);
            r_evt <= w_fall;
            if (w_fall) r_sym <= w_sym;
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!resetn) begin
            r_state       <= ST_HUNT;
            r_pos         <= '0;
            r_bits        <= '0;
            r_sync_ts     <= '0;
            locked        <= 1'b0;
            frame_err_cnt <= '0;
        end else if (w_timeout) begin
            if (r_state != ST_HUNT) frame_err_cnt <= sat_inc(frame_err_cnt);
            r_state <= ST_HUNT;
            r_pos   <= '0;
            locked  <= 1'b0;
        end else if (r_evt) begin
            case (r_state)
                ST_HUNT: begin
                    if (r_sym == c_sym_pi) r_state <= ST_SYNC1;
                end
                ST_SYNC1: begin
                    if (r_sym == c_sym_pi) begin
                        r_state   <= ST_DECODE;
                        r_pos     <= 7'd1;
                        r_bits    <= '0;
                        r_sync_ts <= r_rise_ts;
                    end else begin
                        if (r_sym == c_sym_err) frame_err_cnt <= sat_inc(frame_err_cnt);
                        r_state <= ST_HUNT;
                        locked  <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    if (!w_sym_ok) begin
                        frame_err_cnt <= sat_inc(frame_err_cnt);
                        r_state       <= ST_HUNT;
                        r_pos         <= '0;
                        locked        <= 1'b0;
                    end else if (r_pos == 7'd99) begin
                        r_state <= ST_SYNC1;
                        r_pos   <= '0;
                        locked  <= 1'b1;
                    end else begin
                        if (!w_expect_pi) r_bits[r_pos] <= r_sym[0];
                        r_pos <= r_pos + 7'd1;
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    // A frame committed while a previous one is still streaming is dropped,
    // leaving the buffered frame untouched.
    always_ff @(posedge clk_50MHz) begin
        if (!resetn) begin
            r_out_state    <= OUT_IDLE;
            r_beat         <= '0;
            r_buf_ts       <= '0;
            r_buf_bits     <= '0;
            m_axis_tdata   <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            frame_drop_cnt <= '0;
        end else begin
            case (r_out_state)
                OUT_IDLE: begin
                    if (w_commit) begin
                        r_buf_ts      <= w_ts64;
                        r_buf_bits    <= r_bits;
                        r_beat        <= '0;
                        m_axis_tdata  <= beat_word(w_ts64, r_bits, 3'd0);
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        r_out_state   <= OUT_SEND;
                    end
                end
                OUT_SEND: begin
                    if (w_commit) frame_drop_cnt <= sat_inc(frame_drop_cnt);
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (r_beat == c_last_beat) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            r_out_state   <= OUT_IDLE;
                        end else begin
                            r_beat       <= r_beat + 3'd1;
                            m_axis_tdata <= beat_word(r_buf_ts, r_buf_bits, r_beat + 3'd1);
                            m_axis_tlast <= ((r_beat + 3'd1) == c_last_beat);
                        end
                    end
                end
                default: r_out_state <= OUT_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irig_frame_decoder.sv
`default_nettype none
// ============================================================================
// tb_irig_frame_decoder : directed vectors for irig_frame_decoder (scaled timing).
// Rev 1.0
// ============================================================================
module tb_irig_frame_decoder;

    localparam int T0 = 14, T1 = 26, TPI = 38, TMO = 100, FL = 4;
    localparam int W0 = 8, W1 = 20, WPI = 32, PERIOD = 40;
`ifdef IRIG_TS_COMP_EN
    localparam logic [63:0] TS_OFF = 64'd0;
`else
    localparam logic [63:0] TS_OFF = 64'(FL + 2);
`endif

    typedef struct {
        logic [99:0] data;
        int          opos;
        int          owidth;
        int          gpos;
        bit          exp_ok;
        logic [99:0] exp_bits;
        logic [15:0] exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] cyc = 64'h0000_0001_FFFF_8000;
    logic        irig_in;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, locked;
    logic [15:0] frame_err_cnt, frame_drop_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] q_data[$];
    bit          q_last[$];

    irig_frame_decoder #(
        .COUNTER_W(64), .FILTER_LEN(FL), .T0_CYC(T0), .T1_CYC(T1),
        .TPI_CYC(TPI), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_50MHz(clk), .resetn(resetn), .counter_in(cyc), .irig_in(irig_in),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .locked(locked), .frame_err_cnt(frame_err_cnt), .frame_drop_cnt(frame_drop_cnt)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 64'd1;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [63:0] ts, input logic [99:0] b, input int idx);
        logic [127:0] bb;
        bb = {28'd0, b};
        case (idx)
            0:       exp_word = ts[31:0];
            1:       exp_word = ts[63:32];
            2:       exp_word = bb[31:0];
            3:       exp_word = bb[63:32];
            4:       exp_word = bb[95:64];
            default: exp_word = bb[127:96];
        endcase
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic pulse(input int w, input bit glitch, output logic [63:0] rise_cyc);
        int lo;
        irig_in  = 1'b1;
        rise_cyc = cyc;
        repeat (w) @(negedge clk);
        irig_in = 1'b0;
        lo = (w + 8 > PERIOD) ? 8 : PERIOD - w;
        if (glitch) begin
            repeat (10) @(negedge clk);
            irig_in = 1'b1;
            repeat (3) @(negedge clk);
            irig_in = 1'b0;
            repeat (lo - 13) @(negedge clk);
        end else begin
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic send_frame(input vec_t v, input int npos, output logic [63:0] pr_cyc);
        pr_cyc = '0;
        for (int p = 0; p < npos; p++) begin
            int w;
            logic [63:0] e;
            if (p == 0 || p % 10 == 9) w = WPI;
            else                       w = v.data[p] ? W1 : W0;
            if (p == v.opos) w = v.owidth;
            pulse(w, p == v.gpos, e);
            if (p == 0) pr_cyc = e;
        end
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk);
        #1 m_axis_tready = v;
        @(negedge clk);
    endtask

    task automatic check_frame(input vec_t v, input logic [63:0] pr_cyc, input string tag);
        int n;
        repeat (20) @(negedge clk);
        n = q_data.size();
        chk({tag, " beats"}, 64'(n), v.exp_ok ? 64'd6 : 64'd0);
        if (v.exp_ok && n == 6) begin
            for (int b = 0; b < 6; b++) begin
                chk($sformatf("%s beat%0d data", tag, b), 64'(q_data[b]),
                    64'(exp_word(pr_cyc + TS_OFF, v.exp_bits, b)));
                chk($sformatf("%s beat%0d tlast", tag, b), 64'(q_last[b]), 64'(b == 5));
            end
        end
        chk({tag, " err_cnt"}, 64'(frame_err_cnt), 64'(v.exp_err));
        chk({tag, " locked"}, 64'(locked), 64'(v.exp_ok));
        q_data.delete();
        q_last.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        vec_t va, vb, vt, vc, vr;
        logic [63:0] pr, pra, dummy;

        vecs[0] = '{100'h4A, -1, 0, -1, 1'b1, 100'h4A, 16'd0};
        vecs[1] = '{100'h20, 2, 13, 3, 1'b1, 100'h20, 16'd0};
        vecs[2] = '{100'h0, 2, 14, -1, 1'b1, 100'h4, 16'd0};
        vecs[3] = '{100'h2_0000_0001_0000_0001_0000_0000, 9, 37, -1, 1'b1,
                    100'h2_0000_0001_0000_0001_0000_0000, 16'd0};
        vecs[4] = '{100'h10, 9, 38, -1, 1'b0, 100'h0, 16'd1};
        vecs[5] = '{100'h4_0000_0000_0000_0000_0000_0800, -1, 0, -1, 1'b1,
                    100'h4_0000_0000_0000_0000_0000_0800, 16'd1};
        va = '{100'h2,   -1, 0, -1, 1'b1, 100'h2,   16'd1};
        vb = '{100'h4,   -1, 0, -1, 1'b1, 100'h4,   16'd1};
        vt = '{100'h0,   -1, 0, -1, 1'b1, 100'h0,   16'd2};
        vc = '{100'h10,  -1, 0, -1, 1'b1, 100'h10,  16'd2};
        vr = '{100'h80,  -1, 0, -1, 1'b1, 100'h80,  16'd2};

        resetn = 1'b0;
        irig_in = 1'b0;
        m_axis_tready = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset tlast", 64'(m_axis_tlast), 64'd0);
        chk("reset tdata", 64'(m_axis_tdata), 64'd0);
        chk("reset locked", 64'(locked), 64'd0);
        chk("reset err_cnt", 64'(frame_err_cnt), 64'd0);
        chk("reset drop_cnt", 64'(frame_drop_cnt), 64'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        pulse(WPI, 1'b0, dummy);
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i], 100, pr);
            check_frame(vecs[i], pr, $sformatf("vec%0d", i));
        end

        // Output stalled across two completed frames.
        set_ready(1'b0);
        send_frame(va, 100, pra);
        repeat (20) @(negedge clk);
        chk("stall A tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("stall A tdata", 64'(m_axis_tdata), 64'(exp_word(pra + TS_OFF, va.exp_bits, 0)));
        send_frame(vb, 100, pr);
        repeat (20) @(negedge clk);
        chk("stall B tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("stall B tdata held", 64'(m_axis_tdata), 64'(exp_word(pra + TS_OFF, va.exp_bits, 0)));
        chk("stall drop_cnt", 64'(frame_drop_cnt), 64'd1);
        chk("stall no beats", 64'(q_data.size()), 64'd0);
        set_ready(1'b1);
        repeat (10) @(negedge clk);
        chk("release beats", 64'(q_data.size()), 64'd6);
        if (q_data.size() == 6) begin
            for (int b = 0; b < 6; b++)
                chk($sformatf("release beat%0d", b), 64'(q_data[b]),
                    64'(exp_word(pra + TS_OFF, va.exp_bits, b)));
        end
        chk("release tvalid low", 64'(m_axis_tvalid), 64'd0);
        q_data.delete();
        q_last.delete();

        // Signal lost mid-frame, then resync.
        send_frame(vt, 31, dummy);
        chk("pre-timeout locked", 64'(locked), 64'd1);
        repeat (150) @(negedge clk);
        chk("timeout locked", 64'(locked), 64'd0);
        chk("timeout err_cnt", 64'(frame_err_cnt), 64'd2);
        chk("timeout no beats", 64'(q_data.size()), 64'd0);
        pulse(WPI, 1'b0, dummy);
        send_frame(vc, 100, pr);
        check_frame(vc, pr, "resync");

        // Reset during a stalled stream.
        set_ready(1'b0);
        send_frame(vr, 100, pr);
        repeat (20) @(negedge clk);
        chk("prereset tvalid", 64'(m_axis_tvalid), 64'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midreset locked", 64'(locked), 64'd0);
        chk("midreset err_cnt", 64'(frame_err_cnt), 64'd0);
        chk("midreset tdata", 64'(m_axis_tdata), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        set_ready(1'b1);
        repeat (20) @(negedge clk);
        chk("postreset no beats", 64'(q_data.size()), 64'd0);
        chk("postreset drop_cnt", 64'(frame_drop_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
